// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// execute_stage : MIPS R2000 EX stage - ALU, iterative mult/div with HI/LO,
//                 EX/MEM pipeline register and HI/LO hazard stall.
// Revision      : 1.0
// ============================================================================
module execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ex_i,
  input  logic [2:0]  m_i,
  input  logic [1:0]  wb_i,
  input  logic [31:0] data_1_i,
  input  logic [31:0] data_2_i,
  input  logic [31:0] imm_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  output logic [31:0] alu_result_o,
  output logic [31:0] write_data_mem_o,
  output logic [4:0]  write_register_o,
  output logic        zero_o,
  output logic [2:0]  m_out_o,
  output logic [1:0]  wb_out_o,
  output logic        busy_o,
  output logic        stall_o
);

  localparam logic [5:0] c_FN_SLL  = 6'h00;
  localparam logic [5:0] c_FN_SRL  = 6'h02;
  localparam logic [5:0] c_FN_SRA  = 6'h03;
  localparam logic [5:0] c_FN_MFHI = 6'h10;
  localparam logic [5:0] c_FN_MTHI = 6'h11;
  localparam logic [5:0] c_FN_MFLO = 6'h12;
  localparam logic [5:0] c_FN_MTLO = 6'h13;
  localparam logic [5:0] c_FN_ADD  = 6'h20;
  localparam logic [5:0] c_FN_ADDU = 6'h21;
  localparam logic [5:0] c_FN_SUB  = 6'h22;
  localparam logic [5:0] c_FN_SUBU = 6'h23;
  localparam logic [5:0] c_FN_AND  = 6'h24;
  localparam logic [5:0] c_FN_OR   = 6'h25;
  localparam logic [5:0] c_FN_XOR  = 6'h26;
  localparam logic [5:0] c_FN_NOR  = 6'h27;
  localparam logic [5:0] c_FN_SLT  = 6'h2A;
  localparam logic [5:0] c_FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

  // Decode
  logic        w_reg_dst, w_alu_src, w_rtype;
  logic [1:0]  w_alu_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_shamt;
  logic [31:0] w_op_b;
  logic        w_is_muldiv, w_is_mthi, w_is_mtlo, w_hilo_op, w_wb_kill, w_signed_op;
  logic [31:0] w_abs_a, w_abs_b;

  assign w_reg_dst   = ex_i[3];
  assign w_alu_op    = ex_i[2:1];
  assign w_alu_src   = ex_i[0];
  assign w_funct     = imm_i[5:0];
  assign w_shamt     = imm_i[10:6];
  assign w_op_b      = w_alu_src ? imm_i : data_2_i;
  assign w_rtype     = (w_alu_op == 2'b10);
  // 0x18..0x1B share funct[5:2] = 0110, 0x10..0x13 share 0100
  assign w_is_muldiv = w_rtype & (w_funct[5:2] == 4'b0110);
  assign w_is_mthi   = w_rtype & (w_funct == c_FN_MTHI);
  assign w_is_mtlo   = w_rtype & (w_funct == c_FN_MTLO);
  assign w_hilo_op   = w_is_muldiv | (w_rtype & (w_funct[5:2] == 4'b0100));
  assign w_wb_kill   = w_is_muldiv | w_is_mthi | w_is_mtlo;
  assign w_signed_op = ~w_funct[0];
  assign w_abs_a     = (w_signed_op & data_1_i[31]) ? -data_1_i : data_1_i;
  assign w_abs_b     = (w_signed_op & data_2_i[31]) ? -data_2_i : data_2_i;

  // Multiply/divide state
  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] opa_q;
  logic [63:0] work_q;
  logic        neg_res_q, neg_rem_q, div0_q;
  logic [31:0] hi_q, lo_q;

  assign busy_o  = (state_q != S_IDLE);
  assign stall_o = busy_o & w_hilo_op;

  // ALU
  logic [31:0] alu_result_d;
  always_comb begin
    alu_result_d = 32'd0;
    case (w_alu_op)
      2'b01: alu_result_d = data_1_i - w_op_b;
      2'b10: begin
        case (w_funct)
          c_FN_ADD, c_FN_ADDU: alu_result_d = data_1_i + w_op_b;
          c_FN_SUB, c_FN_SUBU: alu_result_d = data_1_i - w_op_b;
          c_FN_AND:  alu_result_d = data_1_i & w_op_b;
          c_FN_OR:   alu_result_d = data_1_i | w_op_b;
          c_FN_XOR:  alu_result_d = data_1_i ^ w_op_b;
          c_FN_NOR:  alu_result_d = ~(data_1_i | w_op_b);
          c_FN_SLT:  alu_result_d = {31'd0, $signed(data_1_i) < $signed(w_op_b)};
          c_FN_SLTU: alu_result_d = {31'd0, data_1_i < w_op_b};
          c_FN_SLL:  alu_result_d = data_2_i << w_shamt;
          c_FN_SRL:  alu_result_d = data_2_i >> w_shamt;
          c_FN_SRA:  alu_result_d = $unsigned($signed(data_2_i) >>> w_shamt);
          c_FN_MFHI: alu_result_d = hi_q;
          c_FN_MFLO: alu_result_d = lo_q;
          default:   alu_result_d = 32'd0;
        endcase
      end
      default: alu_result_d = data_1_i + w_op_b;
    endcase
  end

  // One iteration of shift-add multiply / restoring divide; work_q holds
  // {partial product, multiplier} or {remainder, dividend/quotient}.
  logic [32:0] w_mul_sum, w_div_shift, w_div_diff;
  logic [63:0] w_mul_next, w_div_next, w_prod_fixed;
  logic        w_div_ge;
  logic [31:0] w_quo_fixed, w_rem_fixed;

  assign w_mul_sum    = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opa_q} : 33'd0);
  assign w_mul_next   = {w_mul_sum, work_q[31:1]};
  assign w_div_shift  = work_q[63:31];
  assign w_div_diff   = w_div_shift - {1'b0, opa_q};
  assign w_div_ge     = ~w_div_diff[32];
  assign w_div_next   = {(w_div_ge ? w_div_diff[31:0] : w_div_shift[31:0]), work_q[30:0], w_div_ge};
  assign w_prod_fixed = neg_res_q ? -w_mul_next : w_mul_next;
  // Dividing by zero leaves the dividend in the remainder, so only LO needs forcing
  assign w_quo_fixed  = div0_q ? 32'hFFFF_FFFF : (neg_res_q ? -w_div_next[31:0] : w_div_next[31:0]);
  assign w_rem_fixed  = neg_rem_q ? -w_div_next[63:32] : w_div_next[63:32];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      opa_q     <= 32'd0;
      work_q    <= 64'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_is_muldiv) begin
            state_q   <= w_funct[1] ? S_DIV : S_MUL;
            cnt_q     <= 5'd0;
            neg_res_q <= w_signed_op & (data_1_i[31] ^ data_2_i[31]);
            neg_rem_q <= w_signed_op & data_1_i[31];
            div0_q    <= (data_2_i == 32'd0);
            if (w_funct[1]) begin
              opa_q  <= w_abs_b;
              work_q <= {32'd0, w_abs_a};
            end else begin
              opa_q  <= w_abs_a;
              work_q <= {32'd0, w_abs_b};
            end
          end else if (w_is_mthi) begin
            hi_q <= data_1_i;
          end else if (w_is_mtlo) begin
            lo_q <= data_1_i;
          end
        end
        S_MUL: begin
          work_q <= w_mul_next;
          cnt_q  <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            hi_q    <= w_prod_fixed[63:32];
            lo_q    <= w_prod_fixed[31:0];
            state_q <= S_IDLE;
          end
        end
        S_DIV: begin
          work_q <= w_div_next;
          cnt_q  <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            hi_q    <= w_rem_fixed;
            lo_q    <= w_quo_fixed;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // EX/MEM pipeline register
  logic [31:0] alu_result_q, write_data_mem_q;
  logic [4:0]  write_register_q;
  logic        zero_q;
  logic [2:0]  m_out_q;
  logic [1:0]  wb_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result_q     <= 32'd0;
      write_data_mem_q <= 32'd0;
      write_register_q <= 5'd0;
      zero_q           <= 1'b0;
      m_out_q          <= 3'd0;
      wb_out_q         <= 2'd0;
    end else begin
      alu_result_q     <= alu_result_d;
      write_data_mem_q <= data_2_i;
      write_register_q <= w_reg_dst ? rd_i : rt_i;
      zero_q           <= (alu_result_d == 32'd0);
      m_out_q          <= stall_o ? 3'd0 : m_i;
      wb_out_q         <= (stall_o | w_wb_kill) ? 2'd0 : wb_i;
    end
  end

  assign alu_result_o     = alu_result_q;
  assign write_data_mem_o = write_data_mem_q;
  assign write_register_o = write_register_q;
  assign zero_o           = zero_q;
  assign m_out_o          = m_out_q;
  assign wb_out_o         = wb_out_q;

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// tb_execute_stage : scoreboard bench for the EX stage.
// Revision         : 1.0
// ============================================================================
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ex;
  logic [2:0]  m;
  logic [1:0]  wb;
  logic [31:0] data_1, data_2, imm;
  logic [4:0]  rt, rd;
  logic [31:0] alu_result, write_data_mem;
  logic [4:0]  write_register;
  logic        zero;
  logic [2:0]  m_out;
  logic [1:0]  wb_out;
  logic        busy, stall;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk              (clk),
    .rst              (rst),
    .ex_i             (ex),
    .m_i              (m),
    .wb_i             (wb),
    .data_1_i         (data_1),
    .data_2_i         (data_2),
    .imm_i            (imm),
    .rt_i             (rt),
    .rd_i             (rd),
    .alu_result_o     (alu_result),
    .write_data_mem_o (write_data_mem),
    .write_register_o (write_register),
    .zero_o           (zero),
    .m_out_o          (m_out),
    .wb_out_o         (wb_out),
    .busy_o           (busy),
    .stall_o          (stall)
  );

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wdm;
    logic [4:0]  wr;
    logic        z;
    logic [2:0]  mo;
    logic [1:0]  wbo;
  } exp_t;

  typedef struct packed {
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] w, input logic [4:0] r,
                              input logic [2:0] mm, input logic [1:0] wbv);
    mk = '{alu: a, wdm: w, wr: r, z: (a == 32'd0), mo: mm, wbo: wbv};
  endfunction

  function automatic exp_t sample();
    sample = '{alu: alu_result, wdm: write_data_mem, wr: write_register, z: zero,
               mo: m_out, wbo: wb_out};
  endfunction

  task automatic drive(input logic [3:0] e, input logic [2:0] mm, input logic [1:0] w,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic [4:0] t, input logic [4:0] d);
    ex = e; m = mm; wb = w; data_1 = a; data_2 = b; imm = im; rt = t; rd = d;
    #1;
  endtask

  task automatic rtype(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [4:0] d);
    drive(4'b1100, 3'b000, 2'b10, a, b, {21'd0, sh, fn}, 5'd0, d);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_unstall(output int n);
    n = 0;
    while (stall === 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    exp_t o;
    rst = 1'b1;
    drive(4'b0001, 3'b111, 2'b11, 32'h55, 32'h66, 32'h7, 5'd3, 5'd4);
    step();
    step();
    o = sample();
    n_cmp++;
    if (o !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0", o);
    end
    n_cmp++;
    if ({busy, stall} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_busy_stall: got %b want 00", {busy, stall});
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    exp_t e, o;
    rtype(6'h20, 32'd5, 32'd7, 5'd0, 5'd9);
    sb_q.push_back(mk(32'd12, 32'd7, 5'd9, 3'b000, 2'b10));
    step();
    e = sb_q.pop_front();
    o = sample();
    n_cmp++;
    if (o !== e) begin
      n_err++;
      $display("FAIL add: got %h want %h", o, e);
    end
  endtask

  task automatic test_back_to_back_itype();
    exp_t e, o;
    drive(4'b0001, 3'b010, 2'b11, 32'h100, 32'hDEAD, 32'd8, 5'd4, 5'd0);
    sb_q.push_back(mk(32'h108, 32'hDEAD, 5'd4, 3'b010, 2'b11));
    step();
    e = sb_q.pop_front();
    o = sample();
    n_cmp++;
    if (o !== e) begin
      n_err++;
      $display("FAIL lw: got %h want %h", o, e);
    end
    drive(4'b0010, 3'b100, 2'b00, 32'h55, 32'h55, 32'd0, 5'd3, 5'd0);
    sb_q.push_back(mk(32'd0, 32'h55, 5'd3, 3'b100, 2'b00));
    step();
    e = sb_q.pop_front();
    o = sample();
    n_cmp++;
    if (o !== e) begin
      n_err++;
      $display("FAIL beq_sub: got %h want %h", o, e);
    end
  endtask

  task automatic test_alu_funct();
    vec_t vt[$];
    exp_t e, o;
    vt.push_back(vec_t'{6'h20, 5'd0, 32'hF0F000FF, 32'h80000F0F, 32'h70F0100E});
    vt.push_back(vec_t'{6'h23, 5'd0, 32'hF0F000FF, 32'h80000F0F, 32'h70EFF1F0});
    vt.push_back(vec_t'{6'h22, 5'd0, 32'h12345678, 32'h12345678, 32'h00000000});
    vt.push_back(vec_t'{6'h24, 5'd0, 32'hF0F000FF, 32'h80000F0F, 32'h8000000F});
    vt.push_back(vec_t'{6'h25, 5'd0, 32'hF0F000FF, 32'h80000F0F, 32'hF0F00FFF});
    vt.push_back(vec_t'{6'h26, 5'd0, 32'hF0F000FF, 32'h80000F0F, 32'h70F00FF0});
    vt.push_back(vec_t'{6'h27, 5'd0, 32'hF0F000FF, 32'h80000F0F, 32'h0F0FF000});
    vt.push_back(vec_t'{6'h2A, 5'd0, 32'h80000F0F, 32'hF0F000FF, 32'h00000001});
    vt.push_back(vec_t'{6'h2A, 5'd0, 32'h00000001, 32'hFFFFFFFF, 32'h00000000});
    vt.push_back(vec_t'{6'h2B, 5'd0, 32'h80000F0F, 32'hF0F000FF, 32'h00000001});
    vt.push_back(vec_t'{6'h2B, 5'd0, 32'hF0F000FF, 32'h80000F0F, 32'h00000000});
    vt.push_back(vec_t'{6'h00, 5'd4, 32'h00000000, 32'h80000F0F, 32'h0000F0F0});
    vt.push_back(vec_t'{6'h02, 5'd4, 32'h00000000, 32'h80000F0F, 32'h080000F0});
    vt.push_back(vec_t'{6'h03, 5'd4, 32'h00000000, 32'h80000F0F, 32'hF80000F0});
    vt.push_back(vec_t'{6'h3F, 5'd0, 32'h11111111, 32'h22222222, 32'h00000000});
    foreach (vt[i]) begin
      rtype(vt[i].fn, vt[i].a, vt[i].b, vt[i].sh, 5'(i + 1));
      sb_q.push_back(mk(vt[i].r, vt[i].b, 5'(i + 1), 3'b000, 2'b10));
      step();
      e = sb_q.pop_front();
      o = sample();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL alu_funct_%h_%0d: got %h want %h", vt[i].fn, i, o, e);
      end
    end
  endtask

  task automatic test_mthi_mtlo();
    exp_t e, o;
    rtype(6'h11, 32'hCAFE0001, 32'd0, 5'd0, 5'd1);
    sb_q.push_back(mk(32'd0, 32'd0, 5'd1, 3'b000, 2'b00));
    step();
    rtype(6'h13, 32'h12345678, 32'd0, 5'd0, 5'd2);
    sb_q.push_back(mk(32'd0, 32'd0, 5'd2, 3'b000, 2'b00));
    e = sb_q.pop_front();
    o = sample();
    n_cmp++;
    if (o !== e) begin
      n_err++;
      $display("FAIL mthi: got %h want %h", o, e);
    end
    step();
    rtype(6'h10, 32'd0, 32'd0, 5'd0, 5'd3);
    sb_q.push_back(mk(32'hCAFE0001, 32'd0, 5'd3, 3'b000, 2'b10));
    e = sb_q.pop_front();
    o = sample();
    n_cmp++;
    if (o !== e) begin
      n_err++;
      $display("FAIL mtlo: got %h want %h", o, e);
    end
    step();
    rtype(6'h12, 32'd0, 32'd0, 5'd0, 5'd4);
    sb_q.push_back(mk(32'h12345678, 32'd0, 5'd4, 3'b000, 2'b10));
    e = sb_q.pop_front();
    o = sample();
    n_cmp++;
    if (o !== e) begin
      n_err++;
      $display("FAIL mfhi_after_mthi: got %h want %h", o, e);
    end
    step();
    e = sb_q.pop_front();
    o = sample();
    n_cmp++;
    if (o !== e) begin
      n_err++;
      $display("FAIL mflo_after_mtlo: got %h want %h", o, e);
    end
  endtask

  task automatic test_mult();
    exp_t e, o;
    int   n;
    logic bubble_ok;
    rtype(6'h18, 32'd7, 32'hFFFFFFFD, 5'd0, 5'd3);
    sb_q.push_back(mk(32'd0, 32'hFFFFFFFD, 5'd3, 3'b000, 2'b00));
    step();
    e = sb_q.pop_front();
    o = sample();
    n_cmp++;
    if (o !== e || busy !== 1'b1) begin
      n_err++;
      $display("FAIL mult_issue: got %h busy %b want %h busy 1", o, busy, e);
    end
    rtype(6'h10, 32'd0, 32'd0, 5'd0, 5'd5);
    n = 0;
    bubble_ok = 1'b1;
    while (stall === 1'b1 && n < 40) begin
      step();
      n++;
      if (m_out !== 3'd0 || wb_out !== 2'd0) bubble_ok = 1'b0;
    end
    n_cmp++;
    if (n != 32) begin
      n_err++;
      $display("FAIL mult_stall_cycles: got %0d want 32", n);
    end
    n_cmp++;
    if (bubble_ok !== 1'b1) begin
      n_err++;
      $display("FAIL mult_stall_bubble: got non-bubble want m_out/wb_out 0");
    end
    sb_q.push_back(mk(32'hFFFFFFFF, 32'd0, 5'd5, 3'b000, 2'b10));
    step();
    rtype(6'h12, 32'd0, 32'd0, 5'd0, 5'd6);
    sb_q.push_back(mk(32'hFFFFFFEB, 32'd0, 5'd6, 3'b000, 2'b10));
    e = sb_q.pop_front();
    o = sample();
    n_cmp++;
    if (o !== e) begin
      n_err++;
      $display("FAIL mult_mfhi: got %h want %h", o, e);
    end
    n_cmp++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL mult_mflo_stall: got %b want 0", stall);
    end
    step();
    e = sb_q.pop_front();
    o = sample();
    n_cmp++;
    if (o !== e) begin
      n_err++;
      $display("FAIL mult_mflo: got %h want %h", o, e);
    end
  endtask

  task automatic test_div();
    exp_t e, o;
    int   n;
    logic [5:0]  fn  [2] = '{6'h1A, 6'h1B};
    logic [31:0] dvd [2] = '{32'hFFFFFFF9, 32'd100};
    logic [31:0] dvs [2] = '{32'd2, 32'd7};
    logic [31:0] quo [2] = '{32'hFFFFFFFD, 32'd14};
    logic [31:0] rem [2] = '{32'hFFFFFFFF, 32'd2};
    for (int k = 0; k < 2; k++) begin
      rtype(fn[k], dvd[k], dvs[k], 5'd0, 5'd7);
      sb_q.push_back(mk(32'd0, dvs[k], 5'd7, 3'b000, 2'b00));
      step();
      e = sb_q.pop_front();
      o = sample();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL div%0d_issue: got %h want %h", k, o, e);
      end
      rtype(6'h12, 32'd0, 32'd0, 5'd0, 5'd8);
      wait_unstall(n);
      n_cmp++;
      if (n != 32) begin
        n_err++;
        $display("FAIL div%0d_stall_cycles: got %0d want 32", k, n);
      end
      sb_q.push_back(mk(quo[k], 32'd0, 5'd8, 3'b000, 2'b10));
      step();
      rtype(6'h10, 32'd0, 32'd0, 5'd0, 5'd9);
      sb_q.push_back(mk(rem[k], 32'd0, 5'd9, 3'b000, 2'b10));
      e = sb_q.pop_front();
      o = sample();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL div%0d_lo: got %h want %h", k, o, e);
      end
      step();
      e = sb_q.pop_front();
      o = sample();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL div%0d_hi: got %h want %h", k, o, e);
      end
    end
  endtask

  task automatic test_divzero_with_slt();
    exp_t e, o;
    int   n;
    rtype(6'h1B, 32'h1234, 32'd0, 5'd0, 5'd1);
    sb_q.push_back(mk(32'd0, 32'd0, 5'd1, 3'b000, 2'b00));
    step();
    e = sb_q.pop_front();
    o = sample();
    n_cmp++;
    if (o !== e) begin
      n_err++;
      $display("FAIL divz_issue: got %h want %h", o, e);
    end
    rtype(6'h2A, 32'hFFFFFFFF, 32'd1, 5'd0, 5'd8);
    n_cmp++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL slt_busy_stall: got %b want 0", stall);
    end
    sb_q.push_back(mk(32'd1, 32'd1, 5'd8, 3'b000, 2'b10));
    step();
    e = sb_q.pop_front();
    o = sample();
    n_cmp++;
    if (o !== e || busy !== 1'b1) begin
      n_err++;
      $display("FAIL slt_during_busy: got %h busy %b want %h busy 1", o, busy, e);
    end
    rtype(6'h12, 32'd0, 32'd0, 5'd0, 5'd9);
    wait_unstall(n);
    n_cmp++;
    if (n != 31) begin
      n_err++;
      $display("FAIL divz_stall_cycles: got %0d want 31", n);
    end
    sb_q.push_back(mk(32'hFFFFFFFF, 32'd0, 5'd9, 3'b000, 2'b10));
    step();
    rtype(6'h10, 32'd0, 32'd0, 5'd0, 5'd10);
    sb_q.push_back(mk(32'h1234, 32'd0, 5'd10, 3'b000, 2'b10));
    e = sb_q.pop_front();
    o = sample();
    n_cmp++;
    if (o !== e) begin
      n_err++;
      $display("FAIL divz_lo: got %h want %h", o, e);
    end
    step();
    e = sb_q.pop_front();
    o = sample();
    n_cmp++;
    if (o !== e) begin
      n_err++;
      $display("FAIL divz_hi: got %h want %h", o, e);
    end
  endtask

  task automatic test_reset_mid_op();
    exp_t e, o;
    rtype(6'h18, 32'd3, 32'd5, 5'd0, 5'd1);
    sb_q.push_back(mk(32'd0, 32'd5, 5'd1, 3'b000, 2'b00));
    step();
    e = sb_q.pop_front();
    o = sample();
    n_cmp++;
    if (o !== e) begin
      n_err++;
      $display("FAIL rmid_issue: got %h want %h", o, e);
    end
    drive(4'b0000, 3'b000, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    repeat (9) step();
    rst = 1'b1;
    drive(4'b0001, 3'b010, 2'b11, 32'h100, 32'hBEEF, 32'd8, 5'd4, 5'd0);
    step();
    rst = 1'b0;
    o = sample();
    n_cmp++;
    if (o !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_outputs: got %h busy %b want 0 busy 0", o, busy);
    end
    rtype(6'h12, 32'd0, 32'd0, 5'd0, 5'd4);
    n_cmp++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_mflo_stall: got %b want 0", stall);
    end
    sb_q.push_back(mk(32'd0, 32'd0, 5'd4, 3'b000, 2'b10));
    step();
    rtype(6'h10, 32'd0, 32'd0, 5'd0, 5'd5);
    sb_q.push_back(mk(32'd0, 32'd0, 5'd5, 3'b000, 2'b10));
    e = sb_q.pop_front();
    o = sample();
    n_cmp++;
    if (o !== e) begin
      n_err++;
      $display("FAIL rmid_mflo: got %h want %h", o, e);
    end
    step();
    e = sb_q.pop_front();
    o = sample();
    n_cmp++;
    if (o !== e) begin
      n_err++;
      $display("FAIL rmid_mfhi: got %h want %h", o, e);
    end
  endtask

  initial begin
    rst = 1'b1;
    ex = '0; m = '0; wb = '0; data_1 = '0; data_2 = '0; imm = '0; rt = '0; rd = '0;
    test_reset();
    test_add();
    test_back_to_back_itype();
    test_alu_funct();
    test_mthi_mtlo();
    test_mult();
    test_div();
    test_divzero_with_slt();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit reached want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/execute_stage.md
# execute_stage

Execute (EX) stage of the MIPS R2000 pipeline, directly downstream of the decode stage. It consumes the ID/EX values (`ex`, `m`, `wb`, `data_1`, `data_2`, `imm`, `rt`, `rd`) and computes the ALU result and the destination register. It also hosts the iterative multiply/divide unit with HI/LO and registers everything into the EX/MEM pipeline register. While the multiply/divide unit is busy, a dependent HI/LO instruction raises `stall` to hold the upstream stages.

## Interface
- No parameters; all widths are fixed by the ISA.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ex`  in  4  `{reg_dst, alu_op[1:0], alu_src}`.
- `m`  in  3  `{branch, mem_read, mem_write}`.
- `wb`  in  2  `{reg_write, mem_to_reg}`.
- `data_1`, `data_2`  in  32  register operands rs and rt.
- `imm`  in  32  zero-extended immediate; `funct = imm[5:0]`, `shamt = imm[10:6]`.
- `rt`, `rd`  in  5  candidate destination registers.
- `alu_result`  out  32  registered ALU / MFHI / MFLO result.
- `write_data_mem`  out  32  registered `data_2`, used as store data.
- `write_register`  out  5  registered; `rd` if `reg_dst`, else `rt`.
- `zero`  out  1  registered; 1 when the ALU result is 0.
- `m_out`  out  3  registered `m`.
- `wb_out`  out  2  registered `wb`, after suppression rules.
- `busy`  out  1  multiply/divide unit running.
- `stall`  out  1  combinational; upstream holds ID/EX while it is 1.

## Operation
- Operand B is `imm` when `alu_src` is 1, otherwise `data_2`.
- ALU function by `alu_op`:
  - `00` and `11`: add.
  - `01`: subtract.
  - `10`: decoded from `funct`:
    - 0x20/0x21: add. 0x22/0x23: sub. No overflow trap; results wrap mod 2^32.
    - 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR.
    - 0x2A SLT (signed), 0x2B SLTU; both produce 0 or 1.
    - 0x00 SLL, 0x02 SRL, 0x03 SRA: shift `data_2` by `shamt`.
    - 0x10 MFHI, 0x12 MFLO: result is HI or LO.
    - 0x11 MTHI, 0x13 MTLO: HI or LO := `data_1`.
    - 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU: start the multiply/divide unit.
    - Any other `funct`: result 0.
- `wb_out` is forced to 00 for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Multiply/divide FSM:
  - IDLE: a mult/div op that is not stalled, seen at a clock edge, latches magnitudes of the operands (signed ops) or raw operands (unsigned ops), clears the 5-bit counter and enters MUL or DIV. `busy` goes to 1.
  - MUL: shift-add, one bit per cycle.
  - DIV: restoring division, one bit per cycle.
  - On the edge where the counter reaches 31, HI/LO are written with sign fix-up and the FSM returns to IDLE.
  - Sign rules:
    - Signed product is negated when the operand signs differ.
    - Quotient is negative when the signs differ; remainder takes the sign of the dividend.
  - Divide by zero: LO = 0xFFFFFFFF, HI = `data_1`, for both signed and unsigned.
- `stall = busy & (funct ∈ {MFHI, MFLO, MTHI, MTLO, MULT, MULTU, DIV, DIVU}) & (alu_op == 10)`.
- While `stall` is 1:
  - EX/MEM captures a bubble: `m_out` = 0, `wb_out` = 0.
  - HI/LO are not written by the stalled instruction.
- Non-HI/LO instructions flow through normally while `busy` is 1.

## Timing
- ALU path latency is 1 cycle: inputs present before edge N appear on the outputs after edge N.
- Mult/div accepted at edge E0; HI/LO valid after edge E32; `busy` is high from after E0 until after E32.
- A MFHI issued in the cycle after the MULT stalls for 32 cycles, is captured at E33, and reads the new HI.
- MTHI/MTLO while IDLE: HI/LO update at the same edge that captures the instruction.
- Reset values:
  - All registered outputs are 0.
  - HI = LO = 0.
  - FSM in IDLE, counter = 0.
  - `busy` = 0, so `stall` = 0.
- Reset asserted mid-operation aborts it: HI/LO are cleared and the result is discarded.
- Reset has priority over every other event at the same edge.

## Test plan
- R-type ADD: `ex` = 1100, `funct` = 0x20, `data_1` = 5, `data_2` = 7, `rd` = 9 -> next cycle `alu_result` = 12, `write_register` = 9, `wb_out` = 10, `zero` = 0.
- LW: `ex` = 0001, `m` = 010, `wb` = 11, `data_1` = 0x100, `imm` = 8, `rt` = 4 -> `alu_result` = 0x108, `write_register` = 4, `m_out` = 010.
- MULT 7 × 0xFFFFFFFD followed by MFHI, then MFLO:
  - `stall` stays high for 32 cycles.
  - MFHI result = 0xFFFFFFFF; MFLO result = 0xFFFFFFEB.
- DIV 0xFFFFFFF9 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 100 / 7 -> LO = 14, HI = 2.
- DIVU 0x1234 / 0 -> LO = 0xFFFFFFFF, HI = 0x1234. An independent SLT (−1 < 1 -> 1) issued during the busy window completes without stall.
- Assert `rst` 10 cycles into a MULT -> next cycle `busy` = 0, HI = LO = 0, all outputs 0; a following MFLO returns 0 without stalling.
